// File: rtl/r200_pkg.sv
// Shared encodings for the r200 pipeline: load/store size codes, writeback
// selects and the EX/MEM register occupancy states.
package r200_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // func3[1:0] carries the access size; func3[2] only marks unsigned loads
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  function automatic logic is_load(input logic [1:0] wbsel);
    return wbsel == WB_MEM;
  endfunction

endpackage

// File: rtl/ex_mem_store_align.sv
// EX-side store alignment: replicates store data into the active lanes, builds
// byte enables and flags misaligned loads/stores from the low address bits.
module ex_mem_store_align
  import r200_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  input  logic        is_store,
  input  logic        is_load,
  output logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic        misalign
);

  logic [3:0] be_raw;
  logic       mis_raw;

  always_comb begin
    wdata   = rs2;
    be_raw  = 4'b0000;
    mis_raw = 1'b0;
    case (func3[1:0])
      SZ_B: begin
        wdata  = {4{rs2[7:0]}};
        be_raw = 4'b0001 << addr_lo;
      end
      SZ_H: begin
        wdata   = {2{rs2[15:0]}};
        be_raw  = addr_lo[1] ? 4'b1100 : 4'b0011;
        mis_raw = addr_lo[0];
      end
      SZ_W: begin
        be_raw  = 4'b1111;
        mis_raw = (addr_lo != 2'b00);
      end
      default: begin
        be_raw  = 4'b0000;
        mis_raw = 1'b0;
      end
    endcase
  end

  // Only real memory operations can be misaligned; loads never drive enables
  assign byte_en  = is_store ? be_raw : 4'b0000;
  assign misalign = mis_raw & (is_store | is_load);

endmodule

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with a 2-entry skid buffer, flush and store alignment.
// Define EX_MEM_PERF_EN to add stall/flush performance counters.
//
// state | meaning
// EMPTY | no instruction held; ready for EX
// FULL  | main entry presented to MEM; skid free
// SKID  | main stalled and a second instruction parked in skid; ex_ready low
module ex_mem_reg
  import r200_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [XLEN-1:0]    ex_alu_out,
  input  logic [XLEN-1:0]    ex_rs2o,
  input  logic [RADDR_W-1:0] ex_rdaddr,
  input  logic               ex_memwr,
  input  logic               ex_regwr,
  input  logic [1:0]         ex_wbsel,
  input  logic [2:0]         ex_func3,
  input  logic               stall,
  input  logic               flush,
  output logic               mem_valid,
  output logic [XLEN-1:0]    mem_alu_out,
  output logic [XLEN-1:0]    mem_wdata,
  output logic [3:0]         mem_byte_en,
  output logic [RADDR_W-1:0] mem_rdaddr,
  output logic               mem_memwr,
  output logic               mem_regwr,
  output logic [1:0]         mem_wbsel,
  output logic [2:0]         mem_func3,
`ifdef EX_MEM_PERF_EN
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt,
`endif
  output logic               mem_misalign
);

  localparam int EW = 2*XLEN + 4 + RADDR_W + 1 + 1 + 2 + 3 + 1;

  state_t              state;
  logic                main_valid;
  logic                skid_valid;
  logic                accept;
  logic [EW-1:0]       ex_entry;
  logic [EW-1:0]       main_q;
  logic [EW-1:0]       skid_q;

  logic [XLEN-1:0]     al_wdata;
  logic [3:0]          al_byte_en;
  logic                al_misalign;

  logic [XLEN-1:0]     m_alu_out;
  logic [XLEN-1:0]     m_wdata;
  logic [3:0]          m_byte_en;
  logic [RADDR_W-1:0]  m_rdaddr;
  logic                m_memwr;
  logic                m_regwr;
  logic [1:0]          m_wbsel;
  logic [2:0]          m_func3;
  logic                m_misalign;

  ex_mem_store_align u_align (
    .func3    (ex_func3),
    .addr_lo  (ex_alu_out[1:0]),
    .rs2      (ex_rs2o),
    .is_store (ex_memwr),
    .is_load  (is_load(ex_wbsel)),
    .wdata    (al_wdata),
    .byte_en  (al_byte_en),
    .misalign (al_misalign)
  );

  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == SKID);
  assign ex_ready   = ~skid_valid;
  assign accept     = ex_valid & ex_ready;

  assign ex_entry = {ex_alu_out, al_wdata, al_byte_en, ex_rdaddr, ex_memwr,
                     ex_regwr, ex_wbsel, ex_func3, al_misalign};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state  <= FULL;
            main_q <= ex_entry;
          end
        end
        FULL: begin
          if (!stall) begin
            if (accept) main_q <= ex_entry;
            else        state  <= EMPTY;
          end else if (accept) begin
            state  <= SKID;
            skid_q <= ex_entry;
          end
        end
        SKID: begin
          if (!stall) begin
            state  <= FULL;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign {m_alu_out, m_wdata, m_byte_en, m_rdaddr, m_memwr, m_regwr,
          m_wbsel, m_func3, m_misalign} = main_q;

  // Data fields may be stale in a bubble; every qualifier is gated by valid
  assign mem_valid    = main_valid;
  assign mem_alu_out  = m_alu_out;
  assign mem_wdata    = m_wdata;
  assign mem_byte_en  = main_valid ? m_byte_en : 4'b0000;
  assign mem_rdaddr   = m_rdaddr;
  assign mem_memwr    = main_valid & m_memwr & ~m_misalign;
  assign mem_regwr    = main_valid & m_regwr;
  assign mem_wbsel    = m_wbsel;
  assign mem_func3    = m_func3;
  assign mem_misalign = main_valid & m_misalign;

`ifdef EX_MEM_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall && main_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush && main_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed scenarios plus random traffic against a
// queue-based occupancy model with arithmetic store-alignment expectations.
module tb_ex_mem_reg;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        memwr;
    logic        regwr;
    logic [1:0]  wbsel;
    logic [2:0]  f3;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_rs2o;
  logic [4:0]  ex_rdaddr;
  logic        ex_memwr;
  logic        ex_regwr;
  logic [1:0]  ex_wbsel;
  logic [2:0]  ex_func3;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic [31:0] mem_alu_out;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [4:0]  mem_rdaddr;
  logic        mem_memwr;
  logic        mem_regwr;
  logic [1:0]  mem_wbsel;
  logic [2:0]  mem_func3;
  logic        mem_misalign;
`ifdef EX_MEM_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;
  txn_t        q[$];
  logic [31:0] exp_stall = '0;
  logic [31:0] exp_flush = '0;

  ex_mem_reg dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_alu_out   (ex_alu_out),
    .ex_rs2o      (ex_rs2o),
    .ex_rdaddr    (ex_rdaddr),
    .ex_memwr     (ex_memwr),
    .ex_regwr     (ex_regwr),
    .ex_wbsel     (ex_wbsel),
    .ex_func3     (ex_func3),
    .stall        (stall),
    .flush        (flush),
    .mem_valid    (mem_valid),
    .mem_alu_out  (mem_alu_out),
    .mem_wdata    (mem_wdata),
    .mem_byte_en  (mem_byte_en),
    .mem_rdaddr   (mem_rdaddr),
    .mem_memwr    (mem_memwr),
    .mem_regwr    (mem_regwr),
    .mem_wbsel    (mem_wbsel),
    .mem_func3    (mem_func3),
`ifdef EX_MEM_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .mem_misalign (mem_misalign)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                              input logic memwr, input logic regwr, input logic [1:0] wbsel,
                              input logic [2:0] f3);
    txn_t t;
    t.alu = alu; t.rs2 = rs2; t.rd = rd; t.memwr = memwr;
    t.regwr = regwr; t.wbsel = wbsel; t.f3 = f3;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t        t;
    int unsigned r;
    t.alu   = $urandom;
    t.rs2   = $urandom;
    t.rd    = 5'($urandom);
    t.memwr = ($urandom_range(0, 2) == 0);
    t.regwr = 1'($urandom);
    t.wbsel = 2'($urandom_range(0, 2));
    r = $urandom_range(0, 4);
    t.f3 = t.memwr ? 3'($urandom_range(0, 2)) : ((r < 3) ? 3'(r) : 3'(r + 1));
    return t;
  endfunction

  // Expected MEM view of an instruction, from access size in bytes and offset
  task automatic compare();
    txn_t        t;
    int unsigned sz, off;
    logic        mem_op, mis;
    logic [3:0]  be;
    logic [31:0] wd;
    check_eq("valid", mem_valid, q.size() > 0);
    check_eq("ready", ex_ready, q.size() < 2);
    if (q.size() > 0) begin
      t      = q[0];
      sz     = 1 << t.f3[1:0];
      off    = t.alu % 4;
      mem_op = t.memwr || (t.wbsel == 2'd1);
      mis    = mem_op && ((off % sz) != 0);
      be     = t.memwr ? 4'(((1 << sz) - 1) << (off - off % sz)) : 4'd0;
      wd     = (sz == 1) ? t.rs2[7:0] * 32'h01010101 :
               (sz == 2) ? t.rs2[15:0] * 32'h00010001 : t.rs2;
      check_eq("alu_out", mem_alu_out, t.alu);
      check_eq("rdaddr", mem_rdaddr, t.rd);
      check_eq("wbsel", mem_wbsel, t.wbsel);
      check_eq("func3", mem_func3, t.f3);
      check_eq("regwr", mem_regwr, t.regwr);
      check_eq("misalign", mem_misalign, mis);
      check_eq("memwr", mem_memwr, t.memwr && !mis);
      if (t.memwr && !mis) begin
        check_eq("byte_en", mem_byte_en, be);
        check_eq("wdata", mem_wdata, wd);
      end
      if (!t.memwr) check_eq("load_be", mem_byte_en, 0);
    end else begin
      check_eq("bub_memwr", mem_memwr, 0);
      check_eq("bub_regwr", mem_regwr, 0);
      check_eq("bub_mis", mem_misalign, 0);
      check_eq("bub_be", mem_byte_en, 0);
    end
`ifdef EX_MEM_PERF_EN
    check_eq("perf_stall", perf_stall_cnt, exp_stall);
    check_eq("perf_flush", perf_flush_cnt, exp_flush);
`endif
  endtask

  task automatic cycle(input logic v, input txn_t t, input logic st, input logic fl);
    logic acc;
    ex_valid = v; ex_alu_out = t.alu; ex_rs2o = t.rs2; ex_rdaddr = t.rd;
    ex_memwr = t.memwr; ex_regwr = t.regwr; ex_wbsel = t.wbsel; ex_func3 = t.f3;
    stall = st; flush = fl;
    @(posedge clk);
    acc = v && (q.size() < 2);
    if (st && q.size() > 0) exp_stall = exp_stall + 1;
    if (fl && q.size() > 0) exp_flush = exp_flush + 1;
    if (fl) q.delete();
    else begin
      if (!st && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(t);
    end
    #1;
    compare();
  endtask

  txn_t idle, i1, i2, i3;
  logic [31:0] s0, f0;

  initial begin
    idle = '0;
    rst_n = 1'b0;
    ex_valid = 0; ex_alu_out = 0; ex_rs2o = 0; ex_rdaddr = 0; ex_memwr = 0;
    ex_regwr = 0; ex_wbsel = 0; ex_func3 = 0; stall = 0; flush = 0;
    #12;
    check_eq("rst_valid", mem_valid, 0);
    check_eq("rst_ready", ex_ready, 1);
    check_eq("rst_alu", mem_alu_out, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    check_eq("rst_rd", mem_rdaddr, 0);
    compare();
    rst_n = 1'b1;

    // SW aligned, SB lane 3, SH misaligned
    cycle(1, mk(32'h100, 32'hDEADBEEF, 5'd1, 1, 0, 2'd0, 3'b010), 0, 0);
    check_eq("sw_be", mem_byte_en, 4'b1111);
    check_eq("sw_wdata", mem_wdata, 32'hDEADBEEF);
    check_eq("sw_memwr", mem_memwr, 1);
    cycle(1, mk(32'h103, 32'h000000A5, 5'd2, 1, 0, 2'd0, 3'b000), 0, 0);
    check_eq("sb_be", mem_byte_en, 4'b1000);
    check_eq("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    cycle(1, mk(32'h101, 32'h12345678, 5'd3, 1, 0, 2'd0, 3'b001), 0, 0);
    check_eq("sh_mis", mem_misalign, 1);
    check_eq("sh_memwr", mem_memwr, 0);
    cycle(0, idle, 0, 0);

    // I1, I2, I3 back to back with three stall cycles after I1 enters
    i1 = mk(32'h200, 32'h11, 5'd11, 0, 1, 2'd0, 3'b000);
    i2 = mk(32'h204, 32'h22, 5'd12, 0, 1, 2'd0, 3'b000);
    i3 = mk(32'h208, 32'h33, 5'd13, 0, 1, 2'd0, 3'b000);
    cycle(1, i1, 0, 0);
    cycle(1, i2, 1, 0);
    check_eq("skid_ready", ex_ready, 0);
    check_eq("skid_main", mem_rdaddr, 11);
    cycle(1, i3, 1, 0);
    cycle(1, i3, 1, 0);
    cycle(1, i3, 0, 0);
    check_eq("order_i2", mem_rdaddr, 12);
    cycle(1, i3, 0, 0);
    check_eq("order_i3", mem_rdaddr, 13);
    cycle(0, idle, 0, 0);
    check_eq("drained", mem_valid, 0);

    // Flush while in SKID with stall high
    cycle(1, i1, 0, 0);
    cycle(1, i2, 1, 0);
    cycle(1, i3, 1, 1);
    check_eq("flush_valid", mem_valid, 0);
    check_eq("flush_ready", ex_ready, 1);
    check_eq("flush_regwr", mem_regwr, 0);
    cycle(0, idle, 0, 0);

    // Four stalled cycles with a valid main entry, then one flush
    s0 = exp_stall; f0 = exp_flush;
    cycle(1, i1, 0, 0);
    repeat (4) cycle(0, idle, 1, 0);
    cycle(0, idle, 0, 1);
`ifdef EX_MEM_PERF_EN
    check_eq("perf4_stall", perf_stall_cnt, s0 + 4);
    check_eq("perf1_flush", perf_flush_cnt, f0 + 1);
`endif

    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 3) != 0), rand_txn(), ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 19) == 0));
    end

    // Reset in the middle of traffic discards everything held
    cycle(1, i1, 0, 0);
    cycle(1, i2, 1, 0);
    rst_n = 1'b0;
    #2;
    q.delete();
    exp_stall = '0;
    exp_flush = '0;
    check_eq("midrst_valid", mem_valid, 0);
    check_eq("midrst_ready", ex_ready, 1);
    #3 rst_n = 1'b1;
    cycle(0, idle, 0, 0);
    for (int n = 0; n < 100; n++) begin
      cycle(($urandom_range(0, 3) != 0), rand_txn(), ($urandom_range(0, 9) < 5), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX→MEM pipeline register sitting directly downstream of the ID/EX register and the ALU.
- Captures ALU result, store data and writeback control, aligns store data/byte enables, and presents them to data memory and writeback.
- Contains a 2-entry skid buffer so a MEM-side stall never drops an in-flight EX result; back-pressures EX via ex_ready.
- Supports a flush that kills all held instructions.

Parameters:
- XLEN, 32, datapath width
- RADDR_W, 5, register address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous assert, active-low
- ex_valid  in  1  EX holds a real instruction this cycle
- ex_ready  out  1  block can accept; registered; equals !skid_valid
- ex_alu_out  in  XLEN  ALU result / memory address
- ex_rs2o  in  XLEN  store data
- ex_rdaddr  in  RADDR_W  destination register
- ex_memwr  in  1  store
- ex_regwr  in  1  register write
- ex_wbsel  in  2  writeback source select
- ex_func3  in  3  load/store size (000 B, 001 H, 010 W, 100 BU, 101 HU)
- stall  in  1  MEM cannot consume this cycle
- flush  in  1  kill all held and incoming instructions
- mem_valid  out  1  main entry valid
- mem_alu_out  out  XLEN  address/result
- mem_wdata  out  XLEN  lane-replicated store data
- mem_byte_en  out  4  store byte enables
- mem_rdaddr  out  RADDR_W  destination register
- mem_memwr  out  1  qualified store (valid && memwr && !misalign)
- mem_regwr  out  1  qualified register write (valid && regwr)
- mem_wbsel  out  2  writeback select
- mem_func3  out  3  load size for MEM sign extension
- mem_misalign  out  1  valid store or load with misaligned address

Behaviour:
- Reset (async, rst_n=0):
  - state EMPTY; main and skid entries invalid; all data outputs 0.
  - ex_ready=1 (tracks !skid_valid after reset).
- accept = ex_valid && ex_ready.
- States, derived from {main_valid, skid_valid}: EMPTY (0,0), FULL (1,0), SKID (1,1).
- EMPTY:
  - accept → FULL; main loads at the edge; stall is ignored.
  - no accept → stay EMPTY.
- FULL:
  - !stall & accept → FULL; main reloads from EX.
  - !stall & !accept → EMPTY.
  - stall & accept → SKID; skid loads, main holds.
  - stall & !accept → FULL; hold.
- SKID:
  - ex_ready=0, so no accept.
  - !stall → FULL; main loads from skid, skid invalidated, ex_ready rises next cycle.
  - stall → hold.
- flush:
  - highest priority; next state EMPTY.
  - concurrent ex_valid is dropped.
  - data registers may retain stale values, but all qualified outputs are 0 the next cycle.
- Latency: 1 cycle EX→MEM when not stalled. Throughput: 1/cycle.
- Store alignment, computed on entry (EX side) and registered, using a = ex_alu_out[1:0]:
  - SB: byte_en = 0001<<a; wdata = {4{rs2[7:0]}}.
  - SH: byte_en = 0011<<(a[1]*2); wdata = {2{rs2[15:0]}}; misalign if a[0].
  - SW: byte_en = 1111; wdata = rs2; misalign if a≠0.
  - Loads: byte_en = 0; misalign rule uses the same size rules.
  - Misaligned store: mem_memwr forced 0; mem_misalign=1.
- Bubble (mem_valid=0): mem_memwr, mem_regwr, mem_misalign and mem_byte_en are all 0.
- Simultaneous stall and flush: flush wins.
- rst_n deasserted mid-operation: all in-flight entries are discarded.

Optional Feature:
- Macro EX_MEM_PERF_EN.
- When defined, adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments each cycle with stall && mem_valid.
  - perf_flush_cnt increments each cycle flush=1 while any entry is valid.
  - Both are reset to 0 by rst_n and wrap modulo 2^32.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package r200_pkg: func3 size encodings, wbsel encodings, state enum {EMPTY, FULL, SKID}, XLEN default.
- One sub-module ex_mem_store_align: combinational func3/address/rs2 → wdata, byte_en, misalign.
- ex_mem_reg instantiates one ex_mem_store_align on the EX side.

Test Plan:
- Reset, then SW at addr 0x100 with rs2=0xDEADBEEF, no stall → next cycle mem_valid=1, byte_en=1111, wdata=0xDEADBEEF, mem_memwr=1.
- SB at addr 0x103, rs2=0x000000A5 → byte_en=1000, wdata=0xA5A5A5A5.
- SH at addr 0x101 → mem_misalign=1, mem_memwr=0.
- Back-to-back instrs I1, I2, I3 with stall high for 3 cycles after I1 enters:
  - I2 is captured in skid; ex_ready=0 on the following cycle.
  - After stall drops, I2 then I3 appear in order; nothing is lost or duplicated.
- flush asserted while in SKID with stall=1 → next cycle mem_valid=0, ex_ready=1, mem_regwr=0; I1 and I2 never reach MEM.
- EX_MEM_PERF_EN build: 4 stall cycles with valid main, then 1 flush → perf_stall_cnt=4, perf_flush_cnt=1.
